// File: rtl/instruction_decode_logic_if.sv
// Signal bundle between IF/ID, writeback and the decode stage's ID/EX outputs.
// master = the surrounding pipeline (drives IF/ID + WB), slave = the decode stage.
interface instruction_decode_logic_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32
);
  logic [ADDR_WIDTH-1:0]  pc_in;
  logic [INSTR_WIDTH-1:0] instr_in;
  logic                   wb_reg_write;
  logic [4:0]             wb_rd;
  logic [DATA_WIDTH-1:0]  wb_data;
  logic                   id_ex_flush;

  logic                   pc_write;
  logic                   if_id_write;
  logic [ADDR_WIDTH-1:0]  ex_pc;
  logic [DATA_WIDTH-1:0]  ex_rs_data;
  logic [DATA_WIDTH-1:0]  ex_rt_data;
  logic [DATA_WIDTH-1:0]  ex_imm;
  logic [4:0]             ex_rs;
  logic [4:0]             ex_rt;
  logic [4:0]             ex_rd;
  logic [3:0]             ex_alu_ctrl;
  logic                   ex_alu_src;
  logic                   ex_mem_read;
  logic                   ex_mem_write;
  logic                   ex_reg_write;
  logic                   ex_mem_to_reg;
  logic                   ex_branch;
  logic                   ex_jump;
  logic [ADDR_WIDTH-1:0]  ex_jump_target;

  modport master (
    output pc_in, instr_in, wb_reg_write, wb_rd, wb_data, id_ex_flush,
    input  pc_write, if_id_write, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_alu_ctrl, ex_alu_src, ex_mem_read,
           ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump,
           ex_jump_target
  );

  modport slave (
    input  pc_in, instr_in, wb_reg_write, wb_rd, wb_data, id_ex_flush,
    output pc_write, if_id_write, ex_pc, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_alu_ctrl, ex_alu_src, ex_mem_read,
           ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump,
           ex_jump_target
  );
endinterface

// File: rtl/instruction_decode_logic.sv
// MIPS decode stage: register file, control decode, load-use stall and ID/EX buffer.
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle writeback to the read ports.
module instruction_decode_logic #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32
) (
  input logic                     clk,
  input logic                     reset,
  instruction_decode_logic_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [3:0]            alu_ctrl;
    logic                  alu_src;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  branch;
    logic                  jump;
    logic [ADDR_WIDTH-1:0] jump_target;
  } id_ex_t;

  logic [INSTR_WIDTH-1:0] instr;
  logic [5:0]             opcode;
  logic [5:0]             funct;
  logic [4:0]             rs;
  logic [4:0]             rt;
  logic [4:0]             rd;
  logic [ADDR_WIDTH-1:0]  pc_plus4;

  assign instr    = bus.instr_in;
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign pc_plus4 = bus.pc_in + ADDR_WIDTH'(4);

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] regs [32];
  logic [DATA_WIDTH-1:0] rs_data;
  logic [DATA_WIDTH-1:0] rt_data;

  // NOTE: the array is cleared on reset because r1..r31 must read zero after
  // reset; this keeps it a flop array rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (bus.wb_reg_write && (bus.wb_rd != 5'd0)) begin
      regs[bus.wb_rd] <= bus.wb_data;
    end
  end

  always_comb begin
    rs_data = (rs == 5'd0) ? '0 : regs[rs];
    rt_data = (rt == 5'd0) ? '0 : regs[rt];
`ifdef REGFILE_BYPASS_EN
    if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == rs)) rs_data = bus.wb_data;
    if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == rt)) rt_data = bus.wb_data;
`endif
  end

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  id_ex_t dec;
  logic   valid;
  logic   dest_is_rt;
  logic   reads_rt;

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path through
    // the case statements can leave a value unassigned and infer a latch.
    dec        = '0;
    valid      = 1'b0;
    dest_is_rt = 1'b1;
    reads_rt   = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        reads_rt      = 1'b1;
        dest_is_rt    = 1'b0;
        dec.reg_write = 1'b1;
        valid         = 1'b1;
        case (funct)
          FN_ADD:  dec.alu_ctrl = ALU_ADD;
          FN_SUB:  dec.alu_ctrl = ALU_SUB;
          FN_AND:  dec.alu_ctrl = ALU_AND;
          FN_OR:   dec.alu_ctrl = ALU_OR;
          FN_SLT:  dec.alu_ctrl = ALU_SLT;
          default: valid        = 1'b0;
        endcase
      end
      OP_LW: begin
        valid          = 1'b1;
        dec.alu_ctrl   = ALU_ADD;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
      end
      OP_SW: begin
        valid         = 1'b1;
        reads_rt      = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_ADDI: begin
        valid         = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_BEQ: begin
        valid        = 1'b1;
        reads_rt     = 1'b1;
        dec.alu_ctrl = ALU_SUB;
        dec.branch   = 1'b1;
      end
      OP_J: begin
        valid           = 1'b1;
        dec.jump        = 1'b1;
        dec.jump_target = {pc_plus4[ADDR_WIDTH-1 -: 4], instr[25:0], 2'b00};
      end
      default: valid = 1'b0;
    endcase

    if (valid) begin
      dec.pc      = pc_plus4;
      dec.rs_data = rs_data;
      dec.rt_data = rt_data;
      dec.imm     = {{(DATA_WIDTH-16){instr[15]}}, instr[15:0]};
      dec.rs      = rs;
      dec.rt      = rt;
      dec.rd      = dest_is_rt ? rt : rd;
    end else begin
      dec = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Load-use hazard and ID/EX buffer
  // ---------------------------------------------------------------------------
  id_ex_t id_ex_q;
  logic   hz;

  // A pending flush squashes this instruction anyway, so it must not stall fetch.
  assign hz = id_ex_q.mem_read && (id_ex_q.rt != 5'd0) &&
              ((id_ex_q.rt == rs) || ((id_ex_q.rt == rt) && reads_rt)) &&
              !bus.id_ex_flush;

  assign bus.pc_write    = !hz;
  assign bus.if_id_write = !hz;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex_q <= '0;
    end else if (bus.id_ex_flush || hz) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= dec;
    end
  end

  assign bus.ex_pc          = id_ex_q.pc;
  assign bus.ex_rs_data     = id_ex_q.rs_data;
  assign bus.ex_rt_data     = id_ex_q.rt_data;
  assign bus.ex_imm         = id_ex_q.imm;
  assign bus.ex_rs          = id_ex_q.rs;
  assign bus.ex_rt          = id_ex_q.rt;
  assign bus.ex_rd          = id_ex_q.rd;
  assign bus.ex_alu_ctrl    = id_ex_q.alu_ctrl;
  assign bus.ex_alu_src     = id_ex_q.alu_src;
  assign bus.ex_mem_read    = id_ex_q.mem_read;
  assign bus.ex_mem_write   = id_ex_q.mem_write;
  assign bus.ex_reg_write   = id_ex_q.reg_write;
  assign bus.ex_mem_to_reg  = id_ex_q.mem_to_reg;
  assign bus.ex_branch      = id_ex_q.branch;
  assign bus.ex_jump        = id_ex_q.jump;
  assign bus.ex_jump_target = id_ex_q.jump_target;

endmodule

// File: tb/tb_instruction_decode_logic.sv
// Self-checking bench for instruction_decode_logic: decode table, hand-written
// stall/flush/writeback/reset sequences, and random stimulus against a reference model.
module tb_instruction_decode_logic;

  logic clk;
  logic reset;

  instruction_decode_logic_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  instruction_decode_logic #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [6:0]  flags;  // alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump
    logic [31:0] jt;
  } ex_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    ex_t         exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mregs [32];
  ex_t         mex;
  vec_t        vecs [$];

  localparam logic [31:0] NOP_BAD = 32'hFC00_0000;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic ex_t sample();
    ex_t s;
    s.pc      = bus.ex_pc;
    s.rs_data = bus.ex_rs_data;
    s.rt_data = bus.ex_rt_data;
    s.imm     = bus.ex_imm;
    s.rs      = bus.ex_rs;
    s.rt      = bus.ex_rt;
    s.rd      = bus.ex_rd;
    s.alu     = bus.ex_alu_ctrl;
    s.flags   = {bus.ex_alu_src, bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write,
                 bus.ex_mem_to_reg, bus.ex_branch, bus.ex_jump};
    s.jt      = bus.ex_jump_target;
    return s;
  endfunction

  function automatic ex_t mk(input logic [31:0] pc4, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [3:0] alu, input logic [6:0] flags,
                             input logic [31:0] imm, input logic [31:0] jt);
    ex_t e = '0;
    e.pc = pc4; e.rs = rs; e.rt = rt; e.rd = rd; e.alu = alu;
    e.flags = flags; e.imm = imm; e.jt = jt;
    return e;
  endfunction

  task automatic add_vec(input string name, input logic [31:0] instr, input logic [31:0] pc,
                         input ex_t exp);
    vec_t v;
    v.name = name; v.instr = instr; v.pc = pc; v.exp = exp;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wb_reg_write && bus.wb_rd == idx) return bus.wb_data;
`endif
    return mregs[idx];
  endfunction

  function automatic bit m_reads_rt(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
  endfunction

  function automatic ex_t mdl_decode(input logic [31:0] ins, input logic [31:0] pc);
    logic [5:0]  op  = ins[31:26];
    logic [5:0]  fn  = ins[5:0];
    logic [31:0] pc4 = pc + 32'd4;
    logic [31:0] ext = 32'(signed'(ins[15:0]));
    ex_t e = '0;
    bit ok = 1'b1;
    case (op)
      6'h00: begin
        e.rd = ins[15:11]; e.flags = 7'b0001000;
        if      (fn == 6'h20) e.alu = 4'd2;
        else if (fn == 6'h22) e.alu = 4'd6;
        else if (fn == 6'h24) e.alu = 4'd0;
        else if (fn == 6'h25) e.alu = 4'd1;
        else if (fn == 6'h2A) e.alu = 4'd7;
        else ok = 1'b0;
      end
      6'h23: begin e.alu = 4'd2; e.flags = 7'b1101100; e.rd = ins[20:16]; end
      6'h2B: begin e.alu = 4'd2; e.flags = 7'b1010000; e.rd = ins[20:16]; end
      6'h08: begin e.alu = 4'd2; e.flags = 7'b1001000; e.rd = ins[20:16]; end
      6'h04: begin e.alu = 4'd6; e.flags = 7'b0000010; e.rd = ins[20:16]; end
      6'h02: begin e.flags = 7'b0000001; e.rd = ins[20:16];
                   e.jt = {pc4[31:28], ins[25:0], 2'b00}; end
      default: ok = 1'b0;
    endcase
    if (!ok) return '0;
    e.pc = pc4; e.imm = ext;
    e.rs = ins[25:21]; e.rt = ins[20:16];
    e.rs_data = mread(ins[25:21]);
    e.rt_data = mread(ins[20:16]);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] r1 = 5'($urandom_range(0, 7));
    logic [4:0] r2 = 5'($urandom_range(0, 7));
    logic [4:0] r3 = 5'($urandom_range(0, 7));
    logic [15:0] imm = 16'($urandom);
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    case ($urandom_range(0, 9))
      0:       return {6'h00, r1, r2, r3, 5'd0, fns[$urandom_range(0, 4)]};
      1:       return {6'h00, r1, r2, r3, 5'd0, 6'h3F};
      2, 8, 9: return {6'h23, r1, r2, imm};
      3:       return {6'h2B, r1, r2, imm};
      4:       return {6'h08, r1, r2, imm};
      5:       return {6'h04, r1, r2, imm};
      6:       return {6'h02, 26'($urandom)};
      default: return {6'h3F, 26'($urandom)};
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic we,
                       input logic [4:0] wrd, input logic [31:0] wdata, input logic flush);
    bus.instr_in = instr; bus.pc_in = pc;
    bus.wb_reg_write = we; bus.wb_rd = wrd; bus.wb_data = wdata;
    bus.id_ex_flush = flush;
  endtask

  task automatic do_reset();
    drive(NOP_BAD, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mex = '0;
  endtask

  initial begin
    ex_t e;
    bit  hz;

    reset = 1'b1;
    drive(NOP_BAD, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    #2;
    check("reset_ex", sample(), 186'd0);
    check("reset_stall_ctl", {bus.pc_write, bus.if_id_write}, 2'b11);
    tick();
    reset = 1'b0;

    // ---------------- decode table ----------------
    add_vec("add",      32'h00A0_1820, 32'h100, mk(32'h104, 5, 0, 3, 4'd2, 7'b0001000, 32'h0000_1820, 0));
    add_vec("sub",      32'h0043_0822, 32'h100, mk(32'h104, 2, 3, 1, 4'd6, 7'b0001000, 32'h0000_0822, 0));
    add_vec("and",      32'h0022_2024, 32'h100, mk(32'h104, 1, 2, 4, 4'd0, 7'b0001000, 32'h0000_2024, 0));
    add_vec("or",       32'h00E8_3025, 32'h100, mk(32'h104, 7, 8, 6, 4'd1, 7'b0001000, 32'h0000_3025, 0));
    add_vec("slt",      32'h0022_482A, 32'h100, mk(32'h104, 1, 2, 9, 4'd7, 7'b0001000, 32'h0000_482A, 0));
    add_vec("bad_fn",   32'h0022_483F, 32'h100, '0);
    add_vec("addi",     32'h2022_FFFF, 32'h100, mk(32'h104, 1, 2, 2, 4'd2, 7'b1001000, 32'hFFFF_FFFF, 0));
    add_vec("sw",       32'hAC22_0008, 32'h100, mk(32'h104, 1, 2, 2, 4'd2, 7'b1010000, 32'h0000_0008, 0));
    add_vec("beq",      32'h1022_8000, 32'h100, mk(32'h104, 1, 2, 2, 4'd6, 7'b0000010, 32'hFFFF_8000, 0));
    add_vec("j",        32'h0800_0100, 32'h4000_0000,
            mk(32'h4000_0004, 0, 0, 0, 4'd0, 7'b0000001, 32'h0000_0100, 32'h4000_0400));
    add_vec("j_wrap",   32'h0800_0100, 32'hFFFF_FFFC,
            mk(32'h0000_0000, 0, 0, 0, 4'd0, 7'b0000001, 32'h0000_0100, 32'h0000_0400));
    add_vec("bad_op",   32'hFC00_0000, 32'h100, '0);
    add_vec("lw",       32'h8C22_0004, 32'h100, mk(32'h104, 1, 2, 2, 4'd2, 7'b1101100, 32'h0000_0004, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].instr, vecs[i].pc, 1'b0, 5'd0, 32'd0, 1'b0);
      tick();
      check(vecs[i].name, sample(), vecs[i].exp);
    end

    // ---------------- WB then decode reader ----------------
    do_reset();
    drive(NOP_BAD, 32'h0, 1'b1, 5'd5, 32'h1234, 1'b0);
    tick();
    drive(32'h00A0_1820, 32'h200, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    check("wb_add_rs_data", bus.ex_rs_data, 32'h1234);
    check("wb_add_ctl", {bus.ex_rd, bus.ex_alu_ctrl, bus.ex_reg_write}, {5'd3, 4'b0010, 1'b1});

    // ---------------- load-use stall ----------------
    drive(32'h8C22_0004, 32'h204, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    drive(32'h0042_2020, 32'h208, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    check("lu_stall", {bus.pc_write, bus.if_id_write}, 2'b00);
    tick();
    check("lu_bubble", sample(), 186'd0);
    check("lu_release", {bus.pc_write, bus.if_id_write}, 2'b11);
    tick();
    check("lu_add", {bus.ex_rd, bus.ex_alu_ctrl, bus.ex_reg_write, bus.ex_pc},
          {5'd4, 4'b0010, 1'b1, 32'h20C});
    drive(32'h8C20_0004, 32'h20C, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    drive(32'h0000_2020, 32'h210, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    check("lw_r0_no_stall", {bus.pc_write, bus.if_id_write}, 2'b11);
    tick();
    check("lw_r0_next", {bus.ex_rd, bus.ex_reg_write}, {5'd4, 1'b1});

    // ---------------- flush beats hazard ----------------
    drive(32'h8C22_0004, 32'h300, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    drive(32'h0042_2020, 32'h304, 1'b0, 5'd0, 32'd0, 1'b1);
    #1;
    check("flush_hz_pcw", {bus.pc_write, bus.if_id_write}, 2'b11);
    tick();
    check("flush_hz_bubble", sample(), 186'd0);

    // ---------------- same-cycle writeback ----------------
    drive(NOP_BAD, 32'h0, 1'b1, 5'd7, 32'h1111, 1'b0);
    tick();
    drive(32'h00E0_0820, 32'h400, 1'b1, 5'd7, 32'hDEAD, 1'b0);
    tick();
`ifdef REGFILE_BYPASS_EN
    check("wb_same_cycle", bus.ex_rs_data, 32'hDEAD);
`else
    check("wb_same_cycle", bus.ex_rs_data, 32'h1111);
`endif
    drive(32'h00E0_0820, 32'h400, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    check("wb_next_cycle", bus.ex_rs_data, 32'hDEAD);
    drive(32'h0000_0820, 32'h404, 1'b1, 5'd0, 32'd5, 1'b0);
    tick();
    check("r0_write_same", {bus.ex_rs_data, bus.ex_rt_data}, 64'd0);
    drive(32'h0000_0820, 32'h404, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    check("r0_write_after", {bus.ex_rs_data, bus.ex_rt_data}, 64'd0);

    // ---------------- random vs model ----------------
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive(rand_instr(), $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            $urandom, ($urandom_range(0, 7) == 0));
      #1;
      hz = mex.flags[5] && (mex.rt != 0) &&
           ((mex.rt == bus.instr_in[25:21]) ||
            ((mex.rt == bus.instr_in[20:16]) && m_reads_rt(bus.instr_in[31:26]))) &&
           !bus.id_ex_flush;
      check("rand_stall", {bus.pc_write, bus.if_id_write}, hz ? 2'b00 : 2'b11);
      e = (bus.id_ex_flush || hz) ? ex_t'('0) : mdl_decode(bus.instr_in, bus.pc_in);
      if (bus.wb_reg_write && bus.wb_rd != 0) mregs[bus.wb_rd] = bus.wb_data;
      mex = e;
      tick();
      check("rand_idex", sample(), mex);
    end

    // ---------------- asynchronous reset mid-run ----------------
    for (int i = 1; i < 32; i++) begin
      drive(NOP_BAD, 32'h0, 1'b1, 5'(i), 32'hA500_0000 + 32'(i), 1'b0);
      tick();
    end
    drive(32'h2022_0001, 32'h500, 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    check("pre_reset_busy", {bus.ex_reg_write, bus.ex_alu_src}, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_ex", sample(), 186'd0);
    #1;
    reset = 1'b0;
    for (int i = 1; i < 32; i++) begin
      drive({6'h00, 5'(i), 5'(i), 5'd0, 5'd0, 6'h20}, 32'h600, 1'b0, 5'd0, 32'd0, 1'b0);
      tick();
      check($sformatf("reg_cleared_r%0d", i), {bus.ex_rs_data, bus.ex_rt_data}, 64'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
